// File: rtl/av2_cdef_block_loader_pkg.sv
// Shared CDEF loader definitions: geometry defaults, control widths and the
// per-block control bundle used by the loader, its banks and the filter.
package av2_cdef_block_loader_pkg;

  localparam int PIX_W_DEF   = 10;
  localparam int BLK_DIM_DEF = 8;
  localparam int BLK_PIX_DEF = BLK_DIM_DEF * BLK_DIM_DEF;
  localparam int STR_W       = 3;
  localparam int DAMP_W      = 3;

  typedef enum logic {
    PLANE_LUMA   = 1'b0,
    PLANE_CHROMA = 1'b1
  } cdef_plane_e;

  typedef struct packed {
    logic [STR_W-1:0]  strength_y;
    logic [STR_W-1:0]  strength_uv;
    logic [DAMP_W-1:0] damping;
    cdef_plane_e       plane;
  } cdef_ctl_t;

endpackage

// File: rtl/av2_cdef_blk_bank.sv
// One block buffer: BLK_PIX pixel registers plus the block's CDEF controls,
// single write port and a flattened, always-visible read view.
module av2_cdef_blk_bank
  import av2_cdef_block_loader_pkg::*;
#(
  parameter int PIX_W   = PIX_W_DEF,
  parameter int BLK_PIX = BLK_PIX_DEF,
  localparam int IDX_W  = $clog2(BLK_PIX)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [IDX_W-1:0]         idx,
  input  logic [PIX_W-1:0]         data,
  input  logic                     ctl_we,
  input  cdef_ctl_t                ctl,
  output logic [BLK_PIX*PIX_W-1:0] rd_data,
  output cdef_ctl_t                rd_ctl
);

  logic [PIX_W-1:0] mem [BLK_PIX];
  cdef_ctl_t        ctl_q;

  // Contents are cleared on reset so the presented block reads as zero afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < BLK_PIX; k++) mem[k] <= '0;
      ctl_q <= '0;
    end else begin
      if (we)     mem[idx] <= data;
      if (ctl_we) ctl_q    <= ctl;
    end
  end

  for (genvar k = 0; k < BLK_PIX; k++) begin : g_flat
    assign rd_data[k*PIX_W +: PIX_W] = mem[k];
  end

  assign rd_ctl = ctl_q;

endmodule

// File: rtl/av2_cdef_block_loader.sv
// Raster-to-block feeder for CDEF: ping-pong assembles 8x8 blocks from a pixel
// stream and hands complete blocks plus controls to the filter.
module av2_cdef_block_loader
  import av2_cdef_block_loader_pkg::*;
#(
  parameter int PIX_W    = PIX_W_DEF,
  parameter int BLK_DIM  = BLK_DIM_DEF,
  localparam int BLK_PIX = BLK_DIM * BLK_DIM,
  localparam int IDX_W   = $clog2(BLK_PIX)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [PIX_W-1:0]         pix_data,
  input  logic                     pix_valid,
  output logic                     pix_ready,
  input  logic                     pix_last,
  input  logic [STR_W-1:0]         pix_strength_y,
  input  logic [STR_W-1:0]         pix_strength_uv,
  input  logic [DAMP_W-1:0]        pix_damping,
  input  logic                     pix_is_chroma,
  output logic [BLK_PIX*PIX_W-1:0] blk_data,
  output logic [STR_W-1:0]         blk_strength_y,
  output logic [STR_W-1:0]         blk_strength_uv,
  output logic [DAMP_W-1:0]        blk_damping,
  output logic                     blk_is_chroma,
  output logic                     blk_valid,
  input  logic                     blk_ready,
  output logic                     frame_err,
  output logic [1:0]               occupancy
);

  logic [1:0]       full;
  logic [1:0]       full_nxt;
  logic             wr_bank;
  logic             rd_bank;
  logic [IDX_W-1:0] wr_idx;
  logic             accept;
  logic             drain;
  logic             idx_last;
  cdef_ctl_t        in_ctl;

  logic [BLK_PIX*PIX_W-1:0] bank_data [2];
  cdef_ctl_t                bank_ctl  [2];

  assign pix_ready = ~full[wr_bank] & ~flush;
  assign accept    = pix_valid & pix_ready;
  assign blk_valid = full[rd_bank];
  assign drain     = blk_valid & blk_ready;
  assign idx_last  = (wr_idx == IDX_W'(BLK_PIX - 1));

  assign in_ctl = '{strength_y:  pix_strength_y,
                    strength_uv: pix_strength_uv,
                    damping:     pix_damping,
                    plane:       cdef_plane_e'(pix_is_chroma)};

  for (genvar b = 0; b < 2; b++) begin : g_bank
    av2_cdef_blk_bank #(.PIX_W(PIX_W), .BLK_PIX(BLK_PIX)) u_bank (
      .clk     (clk),
      .rst     (rst),
      .we      (accept && (wr_bank == 1'(b))),
      .idx     (wr_idx),
      .data    (pix_data),
      .ctl_we  (accept && (wr_bank == 1'(b)) && (wr_idx == '0)),
      .ctl     (in_ctl),
      .rd_data (bank_data[b]),
      .rd_ctl  (bank_ctl[b])
    );
  end

  // A fill and a drain can land together only on opposite banks, since a full bank blocks writes.
  always_comb begin
    full_nxt = full;
    if (drain)              full_nxt[rd_bank] = 1'b0;
    if (accept && idx_last) full_nxt[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full      <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_idx    <= '0;
      frame_err <= 1'b0;
    end else begin
      full      <= full_nxt;
      frame_err <= accept && (pix_last != idx_last);
      if (drain) rd_bank <= ~rd_bank;
      // Block boundaries come from the pixel count alone; pix_last only feeds the framing check.
      if (flush) begin
        wr_idx <= '0;
      end else if (accept) begin
        if (idx_last) begin
          wr_idx  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_idx <= wr_idx + IDX_W'(1);
        end
      end
    end
  end

  assign blk_data        = bank_data[rd_bank];
  assign blk_strength_y  = bank_ctl[rd_bank].strength_y;
  assign blk_strength_uv = bank_ctl[rd_bank].strength_uv;
  assign blk_damping     = bank_ctl[rd_bank].damping;
  assign blk_is_chroma   = bank_ctl[rd_bank].plane;
  assign occupancy       = {1'b0, full[0]} + {1'b0, full[1]};

endmodule

// File: tb/tb_av2_cdef_block_loader.sv
// Directed scoreboard bench for av2_cdef_block_loader.
module tb_av2_cdef_block_loader;

  localparam int PIX_W = 10;
  localparam int NPIX  = 64;
  localparam int DW    = NPIX * PIX_W;

  logic          clk = 1'b0;
  logic          rst, flush, pix_valid, pix_last, pix_is_chroma, blk_ready;
  logic [PIX_W-1:0] pix_data;
  logic [2:0]    pix_strength_y, pix_strength_uv, pix_damping;
  logic          pix_ready, blk_valid, frame_err, blk_is_chroma;
  logic [DW-1:0] blk_data;
  logic [2:0]    blk_strength_y, blk_strength_uv, blk_damping;
  logic [1:0]    occupancy;

  typedef struct {
    logic [DW-1:0] data;
    logic [9:0]    ctl;
  } exp_blk_t;

  exp_blk_t sb[$];
  int total = 0, passed = 0, failed = 0;
  int fe_cnt = 0;
  bit acc;

  always #5 clk = ~clk;

  av2_cdef_block_loader dut (
    .clk(clk), .rst(rst), .flush(flush),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_last(pix_last),
    .pix_strength_y(pix_strength_y), .pix_strength_uv(pix_strength_uv),
    .pix_damping(pix_damping), .pix_is_chroma(pix_is_chroma),
    .blk_data(blk_data), .blk_strength_y(blk_strength_y), .blk_strength_uv(blk_strength_uv),
    .blk_damping(blk_damping), .blk_is_chroma(blk_is_chroma),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .frame_err(frame_err), .occupancy(occupancy)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample on the falling edge (what the next rising edge will see), then advance one cycle.
  task automatic step();
    exp_blk_t e;
    @(negedge clk);
    acc = pix_valid && pix_ready;
    if (frame_err === 1'b1) fe_cnt++;
    if (blk_valid === 1'b1 && blk_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_blk", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("blk_data", blk_data, e.data);
        chk("blk_ctl", {blk_strength_y, blk_strength_uv, blk_damping, blk_is_chroma}, e.ctl);
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] seq_blk(input int base);
    logic [DW-1:0] d;
    for (int k = 0; k < NPIX; k++) d[k*PIX_W +: PIX_W] = PIX_W'(base + k);
    return d;
  endfunction

  function automatic logic [DW-1:0] rand_blk();
    logic [DW-1:0] d;
    for (int k = 0; k < NPIX; k++) d[k*PIX_W +: PIX_W] = PIX_W'($urandom_range(0, 1023));
    return d;
  endfunction

  // Sends pixels [0, npix) of block d; controls are only valid alongside pixel 0.
  task automatic send_blk(input logic [DW-1:0] d, input logic [9:0] ctl, input int npix,
                          input int last_a, input int last_b, input bit push, output int stalls);
    exp_blk_t e;
    int n;
    stalls = 0;
    if (push) begin
      e.data = d;
      e.ctl  = ctl;
      sb.push_back(e);
    end
    for (int k = 0; k < npix; k++) begin
      pix_data  = d[k*PIX_W +: PIX_W];
      pix_last  = (k == last_a) || (k == last_b);
      {pix_strength_y, pix_strength_uv, pix_damping, pix_is_chroma} = (k == 0) ? ctl : ~ctl;
      pix_valid = 1'b1;
      n = 0;
      do begin
        step();
        n++;
      end while (!acc && n < 400);
      if (!acc) chk("accept_timeout", 0, 1);
      stalls += n - 1;
    end
    pix_valid = 1'b0;
    pix_last  = 1'b0;
  endtask

  task automatic drain_all();
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      step();
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    int st, fe0;
    logic [DW-1:0] d1, d2, d3;
    rst = 1'b1; flush = 1'b0; pix_valid = 1'b0; pix_last = 1'b0; pix_data = '0;
    pix_strength_y = '0; pix_strength_uv = '0; pix_damping = '0; pix_is_chroma = 1'b0;
    blk_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_pix_ready", pix_ready, 1);
    chk("rst_blk_valid", blk_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_blk_data", blk_data, 0);
    chk("rst_blk_ctl", {blk_strength_y, blk_strength_uv, blk_damping, blk_is_chroma}, 0);

    // 1: ramp block, controls strength_y=3, valid one cycle after pixel 63
    blk_ready = 1'b1;
    send_blk(seq_blk(0), {3'd3, 3'd0, 3'd0, 1'b0}, NPIX, 63, 63, 1, st);
    chk("t1_valid_latency", blk_valid, 1);
    chk("t1_strength_y", blk_strength_y, 3);
    drain_all();
    step();
    chk("t1_valid_after_drain", blk_valid, 0);
    chk("t1_no_frame_err", fe_cnt, 0);

    // 2: three blocks against a stalled filter
    blk_ready = 1'b0;
    d1 = rand_blk(); d2 = rand_blk(); d3 = rand_blk();
    send_blk(d1, {3'd1, 3'd2, 3'd3, 1'b1}, NPIX, 63, 63, 1, st);
    send_blk(d2, {3'd4, 3'd5, 3'd6, 1'b0}, NPIX, 63, 63, 1, st);
    chk("t2_occupancy_full", occupancy, 2);
    chk("t2_ready_low", pix_ready, 0);
    step(); step();
    chk("t2_ready_still_low", pix_ready, 0);
    chk("t2_valid_held", blk_valid, 1);
    blk_ready = 1'b1;
    step();
    chk("t2_ready_back", pix_ready, 1);
    send_blk(d3, {3'd7, 3'd7, 3'd1, 1'b1}, NPIX, 63, 63, 1, st);
    drain_all();
    chk("t2_occupancy_empty", occupancy, 0);

    // 3: continuous stream, drained every block
    blk_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      send_blk(rand_blk(), 10'(b * 37 + 5), NPIX, 63, 63, 1, st);
      chk("t3_stalls", st, 0);
    end
    drain_all();
    chk("t3_no_frame_err", fe_cnt, 0);

    // 4: early pix_last at pixel 40 (last also at 63) -> exactly one pulse
    fe0 = fe_cnt;
    send_blk(seq_blk(100), {3'd2, 3'd1, 3'd4, 1'b0}, NPIX, 40, 63, 1, st);
    drain_all();
    step(); step();
    chk("t4_frame_err_once", fe_cnt - fe0, 1);

    // 5: completed block pending, partial block flushed, fresh all-0x3FF block
    blk_ready = 1'b0;
    d1 = rand_blk();
    send_blk(d1, {3'd5, 3'd3, 3'd2, 1'b1}, NPIX, 63, 63, 1, st);
    send_blk(rand_blk(), 10'h155, 20, 63, 63, 0, st);
    flush = 1'b1;
    pix_valid = 1'b1;
    #2;
    chk("t5_ready_in_flush", pix_ready, 0);
    step();
    flush = 1'b0;
    pix_valid = 1'b0;
    chk("t5_occupancy", occupancy, 1);
    send_blk({NPIX{10'h3FF}}, {3'd6, 3'd0, 3'd7, 1'b0}, NPIX, 63, 63, 1, st);
    blk_ready = 1'b1;
    drain_all();

    // 6: reset with one full bank and a partial block in flight
    blk_ready = 1'b0;
    fe0 = fe_cnt;
    send_blk(rand_blk(), 10'h2AA, NPIX, 63, 63, 0, st);
    send_blk(rand_blk(), 10'h0F0, 30, 63, 63, 0, st);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_valid", blk_valid, 0);
    chk("t6_occupancy", occupancy, 0);
    chk("t6_pix_ready", pix_ready, 1);
    chk("t6_blk_data", blk_data, 0);
    chk("t6_frame_err", frame_err, 0);
    blk_ready = 1'b1;
    send_blk(seq_blk(500), {3'd1, 3'd1, 3'd1, 1'b1}, NPIX, 63, 63, 1, st);
    drain_all();
    step();
    chk("t6_no_frame_err", fe_cnt - fe0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
